// File: rtl/id_exe_latch_pkg.sv
// Shared micro-op and register ids for the ID/EXE boundary, plus the latch state encoding.
// Opcode and register values mirror the core's uISA definitions; nothing new is introduced here.
package id_exe_latch_pkg;

  localparam logic [5:0] NOP_op = 6'h00;
  localparam logic [5:0] LD_op  = 6'h01;
  localparam logic [5:0] IN_op  = 6'h02;
  localparam logic [5:0] ADD_op = 6'h03;

  localparam logic [4:0] rR0  = 5'd0;
  localparam logic [4:0] rAF  = 5'd1;
  localparam logic [4:0] rBC  = 5'd2;
  localparam logic [4:0] rDE  = 5'd3;
  localparam logic [4:0] rHL  = 5'd4;
  localparam logic [4:0] rSP  = 5'd5;
  localparam logic [4:0] rA   = 5'd6;
  localparam logic [4:0] rB   = 5'd7;
  localparam logic [4:0] rT32 = 5'd31;

  localparam int BCNT_W = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/id_exe_latch_sat_counter16.sv
// 16-bit event counter that sticks at all-ones; synchronous active-high clear.
// Latency 1 cycle from en_i to cnt_o; no backpressure.
module sat_counter16
  import id_exe_latch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [BCNT_W-1:0] cnt_o
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {BCNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_exe_latch.sv
// ID->EXE pipeline register: one-cycle latency; mem_stall freezes it, load-use bubble injects a NOP, flush kills.
// ID_stall holds IF/ID on mem_stall or an unflushed bubble. DEP_BUBBLE_CNT_EN enables the bubble counter.
module id_exe_latch
  import id_exe_latch_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int PC_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_valid,
  input  logic [5:0]       ID_opcode,
  input  logic [4:0]       ID_Wr_id,
  input  logic [7:0]       ID_Fmask,
  input  logic [4:0]       ID_Rd0_id,
  input  logic [4:0]       ID_Rd1_id,
  input  logic [IMM_W-1:0] ID_imm,
  input  logic [PC_W-1:0]  ID_pc,
  input  logic             bubble,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             EXE_valid,
  output logic [5:0]       EXE_opcode,
  output logic [4:0]       EXE_Wr_id,
  output logic [7:0]       EXE_Fmask,
  output logic [4:0]       EXE_Rd0_id,
  output logic [4:0]       EXE_Rd1_id,
  output logic [IMM_W-1:0] EXE_imm,
  output logic [PC_W-1:0]  EXE_pc,
  output logic             ID_stall,
  output logic [15:0]      bubble_cnt
);

  state_t           state_q, state_d;
  logic             load_nop, load_id;
  logic             valid_q;
  logic [5:0]       opcode_q;
  logic [4:0]       wr_id_q, rd0_id_q, rd1_id_q;
  logic [7:0]       fmask_q;
  logic [IMM_W-1:0] imm_q;
  logic [PC_W-1:0]  pc_q;

  // Priority: flush > mem_stall > bubble > normal advance.
  always_comb begin
    state_d  = state_q;
    load_nop = 1'b0;
    load_id  = 1'b0;
    if (flush) begin
      state_d  = RUN;
      load_nop = 1'b1;
    end else if (mem_stall) begin
      state_d  = HOLD;
    end else if (bubble) begin
      state_d  = ID_valid ? BUBBLE : RUN;
      load_nop = 1'b1;
    end else begin
      state_d  = RUN;
      load_id  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || load_nop) begin
      valid_q  <= 1'b0;
      opcode_q <= NOP_op;
      wr_id_q  <= rR0;
      fmask_q  <= 8'h00;
      rd0_id_q <= rR0;
      rd1_id_q <= rR0;
      imm_q    <= '0;
      pc_q     <= '0;
    end else if (load_id) begin
      valid_q  <= ID_valid;
      opcode_q <= ID_opcode;
      wr_id_q  <= ID_Wr_id;
      fmask_q  <= ID_Fmask;
      rd0_id_q <= ID_Rd0_id;
      rd1_id_q <= ID_Rd1_id;
      imm_q    <= ID_imm;
      pc_q     <= ID_pc;
    end
  end

  assign EXE_valid  = valid_q;
  assign EXE_opcode = opcode_q;
  assign EXE_Wr_id  = wr_id_q;
  assign EXE_Fmask  = fmask_q;
  assign EXE_Rd0_id = rd0_id_q;
  assign EXE_Rd1_id = rd1_id_q;
  assign EXE_imm    = imm_q;
  assign EXE_pc     = pc_q;

  // A flushed bubble must not stall: IF has to fetch the branch target.
  assign ID_stall = mem_stall | (bubble & ID_valid & ~flush);

`ifdef DEP_BUBBLE_CNT_EN
  logic cnt_inc;
  assign cnt_inc = (state_d == BUBBLE);

  sat_counter16 u_bubble_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (cnt_inc),
    .cnt_o (bubble_cnt)
  );
`else
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_exe_latch.sv
// Directed bench for id_exe_latch: load-use, mem stall, flush priority, reset mid-hold, counter saturation.
module tb_id_exe_latch;
  import id_exe_latch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, id_valid, bubble, mem_stall, flush;
  logic [5:0]  id_opcode;
  logic [4:0]  id_wr_id, id_rd0_id, id_rd1_id;
  logic [7:0]  id_fmask;
  logic [15:0] id_imm, id_pc;
  logic        exe_valid, id_stall;
  logic [5:0]  exe_opcode;
  logic [4:0]  exe_wr_id, exe_rd0_id, exe_rd1_id;
  logic [7:0]  exe_fmask;
  logic [15:0] exe_imm, exe_pc, bubble_cnt;

  int checks   = 0;
  int failures = 0;
  int nb       = 0;

  always #5 clk = ~clk;

  id_exe_latch #(.IMM_W(16), .PC_W(16)) dut (
    .clk(clk), .reset(reset),
    .ID_valid(id_valid), .ID_opcode(id_opcode), .ID_Wr_id(id_wr_id), .ID_Fmask(id_fmask),
    .ID_Rd0_id(id_rd0_id), .ID_Rd1_id(id_rd1_id), .ID_imm(id_imm), .ID_pc(id_pc),
    .bubble(bubble), .mem_stall(mem_stall), .flush(flush),
    .EXE_valid(exe_valid), .EXE_opcode(exe_opcode), .EXE_Wr_id(exe_wr_id), .EXE_Fmask(exe_fmask),
    .EXE_Rd0_id(exe_rd0_id), .EXE_Rd1_id(exe_rd1_id), .EXE_imm(exe_imm), .EXE_pc(exe_pc),
    .ID_stall(id_stall), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef DEP_BUBBLE_CNT_EN
    return (n > 65535) ? 16'hFFFF : n[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] wr,
                        input logic [7:0] fm, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [15:0] imm, input logic [15:0] pc);
    id_valid = v; id_opcode = op; id_wr_id = wr; id_fmask = fm;
    id_rd0_id = r0; id_rd1_id = r1; id_imm = imm; id_pc = pc;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_valid"}, {31'd0, exe_valid}, 32'd0);
    chk({tag, "_op"},    {26'd0, exe_opcode}, {26'd0, NOP_op});
    chk({tag, "_wr"},    {27'd0, exe_wr_id}, {27'd0, rR0});
    chk({tag, "_fm"},    {24'd0, exe_fmask}, 32'd0);
    chk({tag, "_rd"},    {22'd0, exe_rd0_id, exe_rd1_id}, 32'd0);
    chk({tag, "_immpc"}, {exe_imm, exe_pc}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; bubble = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    set_id(1'b1, ADD_op, rB, 8'h5A, rA, rB, 16'hDEAD, 16'hBEEF);
    step();
    chk_nop("reset");
    chk("reset_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt(nb)});
    reset = 1'b0;

    // LD rA into EXE
    set_id(1'b1, LD_op, rA, 8'h00, rHL, rR0, 16'h1234, 16'h0100);
    step();
    chk("ld_op",    {26'd0, exe_opcode}, {26'd0, LD_op});
    chk("ld_wr",    {27'd0, exe_wr_id}, {27'd0, rA});
    chk("ld_valid", {31'd0, exe_valid}, 32'd1);
    chk("ld_immpc", {exe_imm, exe_pc}, 32'h1234_0100);

    // Dependent ADD reading rA: one bubble
    set_id(1'b1, ADD_op, rHL, 8'hF0, rA, rHL, 16'h0007, 16'h0102);
    bubble = 1'b1;
    #1 chk("lu_stall", {31'd0, id_stall}, 32'd1);
    step(); nb++;
    chk_nop("lu_nop");
    chk("lu_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt(nb)});
    bubble = 1'b0;
    #1 chk("lu_nostall", {31'd0, id_stall}, 32'd0);
    step();
    chk("add_op",  {26'd0, exe_opcode}, {26'd0, ADD_op});
    chk("add_fm",  {24'd0, exe_fmask}, 32'h0000_00F0);
    chk("add_rd",  {22'd0, exe_rd0_id, exe_rd1_id}, {22'd0, rA, rHL});
    chk("add_pc",  {16'd0, exe_pc}, 32'h0000_0102);
    chk("add_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt(nb)});

    // Memory stall holding LD rHL for 3 cycles
    set_id(1'b1, LD_op, rHL, 8'h00, rSP, rR0, 16'h0002, 16'h0104);
    step();
    set_id(1'b1, ADD_op, rBC, 8'h0F, rDE, rBC, 16'h0033, 16'h0106);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ms_stall", {31'd0, id_stall}, 32'd1);
      step();
      chk("ms_hold", {16'd0, exe_opcode, exe_wr_id, 5'd0}, {16'd0, LD_op, rHL, 5'd0});
      chk("ms_imm",  {exe_imm, exe_pc}, 32'h0002_0104);
    end
    mem_stall = 1'b0;
    step();
    chk("ms_adv", {16'd0, exe_opcode, exe_wr_id, 5'd0}, {16'd0, ADD_op, rBC, 5'd0});

    // flush + mem_stall + bubble: flush wins, ID_stall from mem_stall
    flush = 1'b1; mem_stall = 1'b1; bubble = 1'b1;
    #1 chk("fp_stall", {31'd0, id_stall}, 32'd1);
    step();
    chk_nop("fp_nop");
    chk("fp_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt(nb)});

    // flush + bubble: no stall
    mem_stall = 1'b0;
    #1 chk("fb_stall", {31'd0, id_stall}, 32'd0);
    step();
    chk_nop("fb_nop");
    flush = 1'b0;

    // bubble with an empty ID slot: NOP, no count, no stall
    id_valid = 1'b0;
    #1 chk("bi_stall", {31'd0, id_stall}, 32'd0);
    step();
    chk_nop("bi_nop");
    chk("bi_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt(nb)});

    // Back-to-back bubbles, then a mem_stall arriving in BUBBLE
    set_id(1'b1, IN_op, rA, 8'h81, rR0, rR0, 16'h00FE, 16'h0200);
    step(); nb++;
    step(); nb++;
    chk_nop("bb_nop");
    chk("bb_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt(nb)});
    mem_stall = 1'b1;
    step();
    chk_nop("bh_nop");
    chk("bh_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt(nb)});
    mem_stall = 1'b0; bubble = 1'b0;
    step();
    chk("in_op", {26'd0, exe_opcode}, {26'd0, IN_op});
    chk("in_fm", {24'd0, exe_fmask}, 32'h0000_0081);

    // Reset while in HOLD
    mem_stall = 1'b1;
    step();
    reset = 1'b1;
    #1 chk("rh_stall", {31'd0, id_stall}, 32'd1);
    step(); nb = 0;
    chk_nop("rh_nop");
    chk("rh_cnt", {16'd0, bubble_cnt}, 32'd0);
    reset = 1'b0; mem_stall = 1'b0;
    set_id(1'b1, ADD_op, rB, 8'h22, rA, rB, 16'h0011, 16'h0300);
    step();
    chk("rh_run", {26'd0, exe_opcode}, {26'd0, ADD_op});

`ifdef DEP_BUBBLE_CNT_EN
    bubble = 1'b1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1 nb = 65535;
    chk("sat_pre", {16'd0, bubble_cnt}, {16'd0, exp_cnt(nb)});
    step(); step(); nb += 2;
    chk("sat_cnt", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    bubble = 1'b0;
`else
    bubble = 1'b1;
    step(); step(); nb += 2;
    chk("nocnt", {16'd0, bubble_cnt}, 32'd0);
    bubble = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
